// File: rtl/axi_mem_rd_responder.sv
// AXI4 read-channel subordinate serving instruction-cache refill bursts
// from a single-port synchronous memory with one cycle of read latency.
module axi_mem_rd_responder #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           ID_WIDTH   = 4,
    parameter int unsigned           MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         ar_valid_i,
    output logic                         ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]        ar_addr_i,
    input  logic [ID_WIDTH-1:0]          ar_id_i,
    input  logic [7:0]                   ar_len_i,
    input  logic [2:0]                   ar_size_i,
    input  logic [1:0]                   ar_burst_i,
    output logic                         r_valid_o,
    input  logic                         r_ready_i,
    output logic [DATA_WIDTH-1:0]        r_data_o,
    output logic [ID_WIDTH-1:0]          r_id_o,
    output logic [1:0]                   r_resp_o,
    output logic                         r_last_o,
    output logic                         mem_req_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_i
);
    localparam int unsigned OFF_BITS  = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_BITS  = $clog2(MEM_WORDS);
    localparam int unsigned SPAN_BITS = OFF_BITS + IDX_BITS;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   addr, addr_next, next_addr, step, wrap_mask;
    logic [7:0]              cnt, cnt_next, len;
    logic [ID_WIDTH-1:0]     id;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    accept, issue, pop, credit, in_range, illegal, wrap_legal;
    logic [1:0]              issue_resp;

    logic                    inflight;
    logic [ID_WIDTH-1:0]     inflight_id;
    logic [1:0]              inflight_resp;
    logic                    inflight_last;
    logic [DATA_WIDTH-1:0]   push_data;

    logic [DATA_WIDTH-1:0]   fifo_data [2];
    logic [ID_WIDTH-1:0]     fifo_id   [2];
    logic [1:0]              fifo_resp [2];
    logic                    fifo_last [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              fifo_count;

    assign pop    = r_valid_o && r_ready_i;
    // Counting the beat that lands next edge keeps the FIFO from overflowing.
    assign credit = ({1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop}) < 3'd2;

    assign step       = ADDR_WIDTH'(1) << size;
    assign wrap_mask  = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    assign wrap_legal = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);

    always_comb begin
        next_addr = addr + step;
        if (burst == 2'b00) begin
            next_addr = addr;
        end else if (burst == 2'b10 && wrap_legal) begin
            next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = addr;
        cnt_next   = cnt;
        accept     = 1'b0;
        issue      = 1'b0;
        ar_ready_o = 1'b0;
        case (state)
            IDLE: begin
                ar_ready_o = 1'b1;
                if (ar_valid_i) begin
                    accept     = 1'b1;
                    addr_next  = ar_addr_i;
                    cnt_next   = '0;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (credit) begin
                    issue = 1'b1;
                    if (cnt == len) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next  = cnt + 8'd1;
                        addr_next = next_addr;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // BASE_ADDR is aligned to the memory span, so the range test and the
    // word index reduce to bit fields of the address.
    assign in_range   = addr[ADDR_WIDTH-1:SPAN_BITS] == BASE_ADDR[ADDR_WIDTH-1:SPAN_BITS];
    assign illegal    = burst == 2'b11;
    assign mem_req_o  = issue && in_range && !illegal;
    assign mem_addr_o = mem_req_o ? addr[SPAN_BITS-1:OFF_BITS] : '0;
    assign issue_resp = illegal ? RESP_SLVERR : (in_range ? RESP_OKAY : RESP_DECERR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            addr  <= '0;
            cnt   <= '0;
            id    <= '0;
            len   <= '0;
            size  <= '0;
            burst <= '0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
            cnt   <= cnt_next;
            if (accept) begin
                id    <= ar_id_i;
                len   <= ar_len_i;
                size  <= ar_size_i;
                burst <= ar_burst_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight      <= 1'b0;
            inflight_id   <= '0;
            inflight_resp <= RESP_OKAY;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_id   <= id;
            inflight_resp <= issue_resp;
            inflight_last <= cnt == len;
        end
    end

    // Error beats ride the same one-cycle slot as reads so R order and latency stay uniform.
    assign push_data = (inflight_resp == RESP_OKAY) ? mem_rdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_id[i]   <= '0;
                fifo_resp[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= '0;
        end else begin
            if (inflight) begin
                fifo_data[wr_ptr] <= push_data;
                fifo_id[wr_ptr]   <= inflight_id;
                fifo_resp[wr_ptr] <= inflight_resp;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    assign r_valid_o = fifo_count != 2'd0;
    assign r_data_o  = r_valid_o ? fifo_data[rd_ptr] : '0;
    assign r_id_o    = r_valid_o ? fifo_id[rd_ptr]   : '0;
    assign r_resp_o  = r_valid_o ? fifo_resp[rd_ptr] : '0;
    assign r_last_o  = r_valid_o && fifo_last[rd_ptr];

endmodule
